// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Opcodes, FSM states, ALU and PC-source codes, decode classes.
package cu_pkg;

  localparam int OP_R   = 0;
  localparam int OP_I   = 2;
  localparam int OP_LW  = 4;
  localparam int OP_SW  = 8;
  localparam int OP_BEQ = 16;
  localparam int OP_J   = 32;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic ill;
  } cls_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier: IR to one-hot instruction class.
// Anything outside the six defined opcodes is flagged illegal.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] ir,
  output cls_t                cls
);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      (ir == OPCODE_W'(OP_R)):   cls.r   = 1'b1;
      (ir == OPCODE_W'(OP_I)):   cls.i   = 1'b1;
      (ir == OPCODE_W'(OP_LW)):  cls.lw  = 1'b1;
      (ir == OPCODE_W'(OP_SW)):  cls.sw  = 1'b1;
      (ir == OPCODE_W'(OP_BEQ)): cls.beq = 1'b1;
      (ir == OPCODE_W'(OP_J)):   cls.j   = 1'b1;
      default:                   cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit FSM with retired-instruction counter.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes instead of NOPing.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ack,
  input  logic                zero,
  input  logic                trap_clr,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_write,
  output logic                busy,
  output logic                illegal_op,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_src,
  output logic [CNT_W-1:0]    retired_cnt
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                retire;
  cls_t                cls;

  cu_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .ir (ir_q),
    .cls(cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls.r || cls.i || cls.lw || cls.sw) begin
          state_d = S_EXEC;
        end else if (cls.beq) begin
          state_d = S_BRANCH;
        end else if (cls.j) begin
          state_d = S_JUMP;
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        state_d = (cls.r || cls.i) ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (mem_ack) begin
          if (cls.lw) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
        if (trap_clr) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    illegal_op  = 1'b0;
    alu_op      = '0;
    pc_src      = PC_SRC_SEQ;
    unique case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_EXEC: begin
        alu_op  = (cls.r || cls.i) ? ALUOP_W'(ALU_FUNCT)
                                   : ALUOP_W'(ALU_ADD);
        alu_src = cls.i || cls.lw || cls.sw;
      end
      S_MEM: begin
        mem_read  = cls.lw;
        mem_write = cls.sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = cls.r || cls.i;
        mem_to_reg = cls.lw;
      end
      S_BRANCH: begin
        alu_op   = ALUOP_W'(ALU_SUB);
        pc_src   = PC_SRC_BR;
        pc_write = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JMP;
      end
      S_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Randomized bench for multicycle_cu against a phase-sequence model.
// A second instance with CNT_W=2 checks counter wrap.
module tb_multicycle_cu;

  typedef enum {P_FETCH, P_DEC, P_EXE, P_MEM, P_WB, P_BR, P_JMP, P_TRAP} ph_e;
  typedef struct {
    ph_e p;
    bit  ack;
    bit  clr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [5:0] opcode;
  logic       mem_ack;
  logic       zero;
  logic       trap_clr;

  logic       instr_ready, reg_dst, alu_src, mem_to_reg, reg_write;
  logic       mem_read, mem_write, pc_write, busy, illegal_op;
  logic [1:0] alu_op, pc_src;
  logic [15:0] retired_cnt;

  logic       instr_ready_b, reg_dst_b, alu_src_b, mem_to_reg_b, reg_write_b;
  logic       mem_read_b, mem_write_b, pc_write_b, busy_b, illegal_op_b;
  logic [1:0] alu_op_b, pc_src_b;
  logic [1:0] retired_cnt_b;

  logic [13:0] obs, obs_b;

  int checks = 0;
  int failures = 0;
  int cnt_m = 0;

  always #5 clk = ~clk;

  multicycle_cu u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .instr_ready(instr_ready),
    .mem_ack    (mem_ack),
    .zero       (zero),
    .trap_clr   (trap_clr),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .busy       (busy),
    .illegal_op (illegal_op),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .retired_cnt(retired_cnt)
  );

  multicycle_cu #(
    .CNT_W(2)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .instr_ready(instr_ready_b),
    .mem_ack    (mem_ack),
    .zero       (zero),
    .trap_clr   (trap_clr),
    .reg_dst    (reg_dst_b),
    .alu_src    (alu_src_b),
    .mem_to_reg (mem_to_reg_b),
    .reg_write  (reg_write_b),
    .mem_read   (mem_read_b),
    .mem_write  (mem_write_b),
    .pc_write   (pc_write_b),
    .busy       (busy_b),
    .illegal_op (illegal_op_b),
    .alu_op     (alu_op_b),
    .pc_src     (pc_src_b),
    .retired_cnt(retired_cnt_b)
  );

  assign obs = {instr_ready, busy, reg_dst, alu_src, mem_to_reg,
                reg_write, mem_read, mem_write, pc_write, illegal_op,
                alu_op, pc_src};
  assign obs_b = {instr_ready_b, busy_b, reg_dst_b, alu_src_b,
                  mem_to_reg_b, reg_write_b, mem_read_b, mem_write_b,
                  pc_write_b, illegal_op_b, alu_op_b, pc_src_b};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 0 || op == 2 || op == 4 || op == 8 || op == 16 || op == 32;
  endfunction

  function automatic logic [13:0] exp_ctl(input ph_e p, input logic [5:0] op,
                                          input bit z);
    bit isr, isi, islw, issw;
    logic rdy, bz, rd, as, mr, rw, mrd, mw, pw, il;
    logic [1:0] ao, ps;
    isr = op == 0; isi = op == 2; islw = op == 4; issw = op == 8;
    rdy = 0; bz = 1; rd = 0; as = 0; mr = 0; rw = 0;
    mrd = 0; mw = 0; pw = 0; il = 0; ao = 0; ps = 0;
    case (p)
      P_FETCH: begin rdy = 1; bz = 0; end
      P_EXE: begin
        ao = (isr || isi) ? 2'b10 : 2'b00;
        as = isi || islw || issw;
      end
      P_MEM: begin mrd = islw; mw = issw; end
      P_WB: begin rw = 1; rd = isr || isi; mr = islw; end
      P_BR: begin ao = 2'b01; ps = 2'b01; pw = z; end
      P_JMP: begin pw = 1; ps = 2'b10; end
      P_TRAP: il = 1;
      default: ;
    endcase
    return {rdy, bz, rd, as, mr, rw, mrd, mw, pw, il, ao, ps};
  endfunction

  function automatic step_t mk(input ph_e p, input bit ack, input bit clr);
    step_t s;
    s.p = p; s.ack = ack; s.clr = clr;
    return s;
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
  task automatic run_instr(input logic [5:0] op, input int n, input bit z,
                           input int cd);
    step_t sq[$];
    bit counted;
    counted = 1;
    check("rdy", 32'(obs[13]), 32'd1);
    sq.push_back(mk(P_DEC, 0, 0));
    if (op == 0 || op == 2) begin
      sq.push_back(mk(P_EXE, 0, 0));
      sq.push_back(mk(P_WB, 0, 0));
    end else if (op == 4 || op == 8) begin
      sq.push_back(mk(P_EXE, 0, 0));
      for (int k = 1; k <= n; k++) sq.push_back(mk(P_MEM, k == n, 0));
      if (op == 4) sq.push_back(mk(P_WB, 0, 0));
    end else if (op == 16) begin
      sq.push_back(mk(P_BR, 0, 0));
    end else if (op == 32) begin
      sq.push_back(mk(P_JMP, 0, 0));
    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
      for (int k = 0; k <= cd; k++) sq.push_back(mk(P_TRAP, 0, k == cd));
      counted = 0;
`endif
    end
    instr_valid = 1'b1;
    opcode = op;
    zero = z;
    @(negedge clk);
    opcode = 6'($urandom);
    foreach (sq[k]) begin
      check("ctl", 32'(obs), 32'(exp_ctl(sq[k].p, op, z)));
      check("ctl_b", 32'(obs_b), 32'(exp_ctl(sq[k].p, op, z)));
      instr_valid = 1'($urandom);
      mem_ack = (sq[k].p == P_MEM) ? sq[k].ack : 1'($urandom);
      trap_clr = (sq[k].p == P_TRAP) ? sq[k].clr : 1'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    trap_clr = 1'b0;
    if (counted) cnt_m++;
    check("fetch", 32'(obs), 32'(exp_ctl(P_FETCH, 6'd0, 1'b0)));
    check("cnt", 32'(retired_cnt), 32'(cnt_m % 65536));
    check("cnt_b", 32'(retired_cnt_b), 32'(cnt_m % 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    opcode = 6'd0;
    mem_ack = 1'b0;
    zero = 1'b0;
    trap_clr = 1'b0;
    #3;
    check("rst_ctl", 32'(obs), 32'(exp_ctl(P_FETCH, 6'd0, 1'b0)));
    check("rst_cnt", 32'(retired_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(6'd0, 1, 1'b0, 0);
    run_instr(6'd4, 3, 1'b0, 0);
    run_instr(6'd16, 1, 1'b1, 0);
    run_instr(6'd16, 1, 1'b0, 0);
    run_instr(6'd3, 1, 1'b0, 2);
    run_instr(6'd32, 1, 1'b0, 0);
    run_instr(6'd8, 1, 1'b0, 0);
    run_instr(6'd2, 1, 1'b0, 0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 6))
        0: op = 6'd0;
        1: op = 6'd2;
        2: op = 6'd4;
        3: op = 6'd8;
        4: op = 6'd16;
        5: op = 6'd32;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_instr(op, int'($urandom_range(1, 4)), 1'($urandom),
                int'($urandom_range(0, 3)));
    end

    // Reset while a store waits on memory
    instr_valid = 1'b1;
    opcode = 6'd8;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sw_mem", 32'(obs), 32'(exp_ctl(P_MEM, 6'd8, 1'b0)));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cnt_m = 0;
    check("rst_mw", 32'(mem_write), 32'd0);
    check("rst_ctl2", 32'(obs), 32'(exp_ctl(P_FETCH, 6'd0, 1'b0)));
    check("rst_cnt2", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_instr(6'd0, 1, 1'b0, 0);
    check("wrap", 32'(retired_cnt_b), 32'd1);
    check("nowrap", 32'(retired_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 2, ALU operation code width.
REQ-003 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports instr_valid  in  1 and opcode  in  OPCODE_W: instruction offer.
REQ-007 SHALL have port instr_ready  out  1: controller accepts opcode this cycle.
REQ-008 SHALL have ports mem_ack  in  1 (memory access complete) and zero  in  1 (ALU equal flag).
REQ-009 SHALL have port trap_clr  in  1, which releases the trap state.
REQ-010 SHALL have 1-bit outputs reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, pc_write, busy and illegal_op, plus alu_op  out  ALUOP_W and pc_src  out  2.
REQ-011 SHALL have port retired_cnt  out  CNT_W: count of retired instructions.

Function
REQ-012 SHALL hold states FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP and TRAP.
REQ-013 SHALL use opcodes R=0, I=2, LW=4, SW=8, BEQ=16 and J=32; any other value is illegal.
REQ-014 SHALL drive instr_ready=1 only in FETCH, latch opcode into the IR when instr_valid&&instr_ready, move to DECODE, and ignore instr_valid in every other state.
REQ-015 SHALL leave DECODE after one cycle: R, I, LW and SW go to EXEC; BEQ goes to BRANCH; J goes to JUMP; illegal opcodes follow REQ-026/027.
REQ-016 SHALL spend one cycle in EXEC with alu_op=10 for R/I and 00 for LW/SW, and alu_src=1 for I/LW/SW; R/I then go to WB and LW/SW go to MEM.
REQ-017 SHALL hold mem_read (LW) or mem_write (SW) in MEM until mem_ack=1, including mem_ack in the entry cycle; LW then goes to WB and SW retires to FETCH.
REQ-018 SHALL assert reg_write for exactly one WB cycle, with reg_dst=1 for R/I and mem_to_reg=1 for LW, then retire to FETCH.
REQ-019 SHALL, in BRANCH, drive alu_op=01, pc_src=01 and pc_write=zero, then retire to FETCH.
REQ-020 SHALL, in JUMP, drive pc_write=1 and pc_src=10, then retire to FETCH.
REQ-021 SHALL drive every control output not named for the current state to 0, decoded from registered state and IR only.
REQ-022 SHALL set busy=1 in every state except FETCH.
REQ-023 SHALL increment retired_cnt by one per retire and wrap modulo 2^CNT_W.
REQ-024 SHALL meet these latencies from accept to the next instr_ready, with N the number of MEM cycles (N>=1): R/I 3 cycles, LW 3+N, SW 2+N, BEQ/J 2.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-instruction, force FETCH, IR=0, retired_cnt=0 and all outputs 0 except instr_ready=1, abandoning any pending memory access.

Configuration
REQ-026 SHALL, with CU_ILLEGAL_TRAP_EN defined, move from DECODE to TRAP on an illegal opcode, hold illegal_op=1 and instr_ready=0, return to FETCH on the cycle after trap_clr=1, and not count the instruction as retired.
REQ-027 SHALL, without CU_ILLEGAL_TRAP_EN, retire an illegal opcode as a NOP (DECODE->FETCH, counted), keep illegal_op=0 and ignore trap_clr.

Structure
REQ-028 SHALL place the opcode constants, the state enum, and the pc_src and alu_op encodings in shared package cu_pkg.
REQ-029 SHALL contain one combinational sub-module cu_decode that maps IR to an instruction-class one-hot.

Verification
REQ-030 SHALL cover: opcode 0 accepted -> instr_ready returns after 3 cycles, reg_write and reg_dst high in WB, retired_cnt=1.
REQ-031 SHALL cover: opcode 4 with mem_ack delayed 3 cycles -> mem_read high for 3 cycles, mem_to_reg=1 in WB, total latency 6.
REQ-032 SHALL cover: opcode 16 with zero=1, then zero=0 -> pc_write 1 then 0, pc_src=01 both times.
REQ-033 SHALL cover: opcode 3 -> with the macro, illegal_op held until trap_clr and count unchanged; without it, NOP and count+1.
REQ-034 SHALL cover: rst_n low during MEM of SW -> mem_write=0 immediately, state FETCH, retired_cnt=0; with CNT_W=2, 5 retires -> retired_cnt=1.
